// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM stage: opcodes, FSM states, access sizes and decode helpers.
package mem_access_unit_pkg;

    localparam logic [5:0] EXE_LB_OPC  = 6'b100000;
    localparam logic [5:0] EXE_LH_OPC  = 6'b100001;
    localparam logic [5:0] EXE_LW_OPC  = 6'b100011;
    localparam logic [5:0] EXE_LBU_OPC = 6'b100100;
    localparam logic [5:0] EXE_LHU_OPC = 6'b100101;
    localparam logic [5:0] EXE_SB_OPC  = 6'b101000;
    localparam logic [5:0] EXE_SH_OPC  = 6'b101001;
    localparam logic [5:0] EXE_SW_OPC  = 6'b101011;

    typedef enum logic [0:0] {
        MA_IDLE   = 1'b0,
        MA_ACCESS = 1'b1
    } ma_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Unknown opcodes fall back to a full word access
    function automatic size_e opc_size(input logic [5:0] opc);
        case (opc)
            EXE_LB_OPC, EXE_LBU_OPC, EXE_SB_OPC: opc_size = SZ_B;
            EXE_LH_OPC, EXE_LHU_OPC, EXE_SH_OPC: opc_size = SZ_H;
            default:                             opc_size = SZ_W;
        endcase
    endfunction

    function automatic logic opc_signed(input logic [5:0] opc);
        case (opc)
            EXE_LB_OPC, EXE_LH_OPC: opc_signed = 1'b1;
            default:                opc_signed = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            SZ_H:    misaligned = lo[0];
            SZ_W:    misaligned = (lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Byte-lane steering: store strobes/replicated data and load lane select with extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr,
    input  logic [31:0] sd,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_addr,
    input  logic        ld_signed,
    input  logic [31:0] rdata,
    output logic [3:0]  strb,
    output logic [31:0] wdata,
    output logic [31:0] load_val
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store strobes and lane-replicated write data
    always_comb begin
        case (st_size)
            SZ_B: begin
                strb  = 4'b0001 << st_addr;
                wdata = {4{sd[7:0]}};
            end
            SZ_H: begin
                strb  = st_addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{sd[15:0]}};
            end
            default: begin
                strb  = 4'b1111;
                wdata = sd;
            end
        endcase
    end

    // Load lane select followed by sign or zero extension
    always_comb begin
        case (ld_addr)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        half_s = ld_addr[1] ? rdata[31:16] : rdata[15:0];
        case (ld_size)
            SZ_B:    load_val = {{24{ld_signed & byte_s[7]}}, byte_s};
            SZ_H:    load_val = {{16{ld_signed & half_s[15]}}, half_s};
            default: load_val = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage of the cqu_mips pipeline: data-memory req/ack handshake and write-back register.
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned halfword/word accesses with bus_err.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic [4:0]  write_reg_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] store_data_in,
    input  logic [31:0] inst_in,
    output logic        dreq,
    output logic        dwe,
    output logic [31:0] daddr,
    output logic [3:0]  dwstrb,
    output logic [31:0] dwdata,
    input  logic        dack,
    input  logic [31:0] drdata,
    output logic        stall_out,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg,
    output logic        wb_we,
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    ma_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;

    // Stage register: the instruction currently owned by this stage
    logic        st_wb_pend_r;
    logic        st_is_store_r;
    logic        st_reg_write_r;
    logic        st_mem_to_reg_r;
    logic [4:0]  st_write_reg_r;
    logic [31:0] st_alu_r;
    logic [1:0]  st_size_r;
    logic        st_signed_r;
    logic [1:0]  st_addr_lo_r;

    logic [1:0]  in_size_s;
    logic        in_mem_s;
    logic        in_misalign_s;
    logic        stall_s;
    logic [3:0]  strb_s;
    logic [31:0] wdata_s;
    logic [31:0] load_val_s;
    logic        unused_s;

    assign in_size_s = opc_size(inst_in[31:26]);
    assign in_mem_s  = mem_read_in | mem_write_in;
    assign unused_s  = ^inst_in[25:0];

`ifdef MEM_ALIGN_CHECK_EN
    assign in_misalign_s = in_mem_s & misaligned(in_size_s, mem_addr_in[1:0]);
`else
    assign in_misalign_s = 1'b0;
`endif

    // The ack cycle releases the stall so the next instruction latches alongside completion
    assign stall_s   = (state_r == MA_ACCESS) & ~dack;
    assign stall_out = stall_s;

    mem_lane_align u_lane (
        .st_size   (in_size_s),
        .st_addr   (mem_addr_in[1:0]),
        .sd        (store_data_in),
        .ld_size   (st_size_r),
        .ld_addr   (st_addr_lo_r),
        .ld_signed (st_signed_r),
        .rdata     (drdata),
        .strb      (strb_s),
        .wdata     (wdata_s),
        .load_val  (load_val_s)
    );

    // FSM, wait counter, stage register and every registered output
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r         <= MA_IDLE;
            cnt_r           <= '0;
            st_wb_pend_r    <= 1'b0;
            st_is_store_r   <= 1'b0;
            st_reg_write_r  <= 1'b0;
            st_mem_to_reg_r <= 1'b0;
            st_write_reg_r  <= 5'd0;
            st_alu_r        <= 32'd0;
            st_size_r       <= 2'd0;
            st_signed_r     <= 1'b0;
            st_addr_lo_r    <= 2'd0;
            dreq            <= 1'b0;
            dwe             <= 1'b0;
            daddr           <= 32'd0;
            dwstrb          <= 4'd0;
            dwdata          <= 32'd0;
            wb_data         <= 32'd0;
            wb_reg          <= 5'd0;
            wb_we           <= 1'b0;
            bus_err         <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state_r)
                MA_IDLE: begin
                    if (st_wb_pend_r) begin
                        wb_data <= st_alu_r;
                        wb_reg  <= st_write_reg_r;
                        wb_we   <= st_reg_write_r;
                    end else begin
                        wb_we <= 1'b0;
                    end
                end
                MA_ACCESS: begin
                    if (dack) begin
                        cnt_r <= '0;
                        if (st_is_store_r) begin
                            wb_we <= 1'b0;
                        end else begin
                            wb_data <= st_mem_to_reg_r ? load_val_s : st_alu_r;
                            wb_reg  <= st_write_reg_r;
                            wb_we   <= st_reg_write_r;
                        end
                    end else if (cnt_r == TMO_LAST) begin
                        cnt_r   <= '0;
                        state_r <= MA_IDLE;
                        dreq    <= 1'b0;
                        dwe     <= 1'b0;
                        bus_err <= 1'b1;
                        wb_we   <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        wb_we <= 1'b0;
                    end
                end
                default: begin
                    state_r <= MA_IDLE;
                    dreq    <= 1'b0;
                    wb_we   <= 1'b0;
                end
            endcase

            if (!stall_s) begin
                st_wb_pend_r    <= ~in_mem_s;
                st_is_store_r   <= mem_write_in;
                st_reg_write_r  <= reg_write_in;
                st_mem_to_reg_r <= mem_to_reg_in;
                st_write_reg_r  <= write_reg_in;
                st_alu_r        <= alu_result_in;
                st_size_r       <= in_size_s;
                st_signed_r     <= opc_signed(inst_in[31:26]);
                st_addr_lo_r    <= mem_addr_in[1:0];
                if (in_mem_s && !in_misalign_s) begin
                    state_r <= MA_ACCESS;
                    dreq    <= 1'b1;
                    dwe     <= mem_write_in;
                    daddr   <= {mem_addr_in[31:2], 2'b00};
                    dwstrb  <= mem_write_in ? strb_s : 4'b0000;
                    dwdata  <= mem_write_in ? wdata_s : 32'd0;
                end else begin
                    state_r <= MA_IDLE;
                    dreq    <= 1'b0;
                    dwe     <= 1'b0;
                    dwstrb  <= 4'b0000;
                    dwdata  <= 32'd0;
                    bus_err <= in_misalign_s;
                end
            end
        end
    end

endmodule
